// File: rtl/fm_accum_ram.sv
// fm_accum_ram: feature-map buffer with block overwrite/accumulate writes, row reads and a clear sweep
module fm_accum_ram #(
    parameter int DATA_WIDTH    = 16,
    parameter int PARA_X        = 3,
    parameter int PARA_Y        = 3,
    parameter int DEPTH         = 72,
    parameter int WR_ADDR_WIDTH = 3,
    parameter int RD_ADDR_WIDTH = 5,
    parameter int SATURATE      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic                                  wr_mode,
    input  logic [WR_ADDR_WIDTH-1:0]              wr_addr,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]   wr_data,
    output logic                                  wr_done,
    input  logic                                  rd_en,
    input  logic [RD_ADDR_WIDTH-1:0]              rd_addr,
    output logic [PARA_Y*DATA_WIDTH-1:0]          rd_data,
    output logic                                  rd_valid,
    input  logic                                  clear_start,
    output logic                                  busy
);
    localparam int BLK   = PARA_X * PARA_Y;
    localparam int NBLK  = DEPTH / BLK;
    localparam int NROW  = DEPTH / PARA_Y;
    localparam int RW    = (NROW > 1) ? $clog2(NROW) : 1;
    localparam int ROW_W = PARA_Y * DATA_WIDTH;
    localparam int BLK_W = BLK * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACC, CLEAR} state_t;

    state_t                   state_q, state_d;
    logic [WR_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d, acc_addr_q, acc_addr_d, w_addr;
    logic [BLK_W-1:0]         acc_old_q, acc_old_d, acc_data_q, acc_data_d;
    logic [BLK_W-1:0]         old_blk, sum_blk, w_blk;
    logic                     wr_done_q, wr_done_d, rd_valid_q, rd_valid_d;
    logic [ROW_W-1:0]         rd_data_q, rd_data_d;
    logic [ROW_W-1:0]         mem_q [NROW];
    logic                     accept, we, clr_last;

    // Element add on a DATA_WIDTH+1 sum; overflow shows as the two top bits differing
    function automatic logic [DATA_WIDTH-1:0] add_el(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        return (SATURATE != 0 && s[DATA_WIDTH] != s[DATA_WIDTH-1]) ?
            {s[DATA_WIDTH], {(DATA_WIDTH-1){~s[DATA_WIDTH]}}} : s[DATA_WIDTH-1:0];
    endfunction

    assign wr_ready = (state_q == IDLE) && !clear_start;
    assign accept   = wr_valid && wr_ready;
    assign clr_last = clr_cnt_q == WR_ADDR_WIDTH'(NBLK - 1);
    assign busy     = state_q == CLEAR;
    assign wr_done  = wr_done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Fetch the addressed block for accumulate and form the per-element sums of the registered operands
    always_comb begin
        old_blk = '0;
        sum_blk = '0;
        for (int i = 0; i < PARA_X; i++)
            old_blk[i*ROW_W +: ROW_W] = (int'(wr_addr) < NBLK) ? mem_q[RW'(int'(wr_addr) * PARA_X + i)] : '0;
        for (int k = 0; k < BLK; k++)
            sum_blk[k*DATA_WIDTH +: DATA_WIDTH] = add_el(acc_old_q[k*DATA_WIDTH +: DATA_WIDTH], acc_data_q[k*DATA_WIDTH +: DATA_WIDTH]);
    end

    // Write port select, FSM next state and registered-output next values; reset cancels any array write
    always_comb begin
        we = !rst && ((accept && !wr_mode && int'(wr_addr) < NBLK) ||
                      (state_q == ACC && int'(acc_addr_q) < NBLK) || state_q == CLEAR);
        w_addr = (state_q == CLEAR) ? clr_cnt_q : (state_q == ACC) ? acc_addr_q : wr_addr;
        w_blk = (state_q == CLEAR) ? '0 : (state_q == ACC) ? sum_blk : wr_data;
        state_d = (state_q == IDLE) ? (clear_start ? CLEAR : (accept && wr_mode) ? ACC : IDLE) :
                  (state_q == ACC) ? IDLE : (clr_last ? IDLE : CLEAR);
        clr_cnt_d = (state_q == CLEAR) ? clr_cnt_q + WR_ADDR_WIDTH'(1) : '0;
        acc_addr_d = accept ? wr_addr : acc_addr_q;
        acc_old_d = accept ? old_blk : acc_old_q;
        acc_data_d = accept ? wr_data : acc_data_q;
        wr_done_d = (accept && !wr_mode) || state_q == ACC;
        rd_valid_d = rd_en && state_q != CLEAR;
        rd_data_d = !rd_valid_d ? rd_data_q : (int'(rd_addr) < NROW) ? mem_q[RW'(rd_addr)] : '0;
    end

    // Array commit, one block (PARA_X rows) per cycle; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < PARA_X; i++)
                mem_q[RW'(int'(w_addr) * PARA_X + i)] <= w_blk[i*ROW_W +: ROW_W];
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            acc_addr_q <= '0;
            acc_old_q  <= '0;
            acc_data_q <= '0;
            wr_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            acc_addr_q <= acc_addr_d;
            acc_old_q  <= acc_old_d;
            acc_data_q <= acc_data_d;
            wr_done_q  <= wr_done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_fm_accum_ram.sv
// tb_fm_accum_ram: directed checks of overwrite, accumulate, saturation, read hazard, clear and reset abort
module tb_fm_accum_ram;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_valid = 1'b0, wr_mode = 1'b0, rd_en = 1'b0, clear_start = 1'b0;
    logic [2:0]   wr_addr = '0;
    logic [143:0] wr_data = '0;
    logic [4:0]   rd_addr = '0;
    logic         wr_ready, wr_done, rd_valid, busy;
    logic [47:0]  rd_data;
    logic         wr_ready1, wr_done1, rd_valid1, busy1;
    logic [47:0]  rd_data1;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    fm_accum_ram #(.SATURATE(1)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mode(wr_mode),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .clear_start(clear_start), .busy(busy)
    );

    fm_accum_ram #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_mode(wr_mode),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done1), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .clear_start(clear_start), .busy(busy1)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_wr(input logic v, input logic m, input logic [2:0] a, input logic [143:0] d);
        wr_valid = v;
        wr_mode  = m;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic set_rd(input logic e, input logic [4:0] a);
        rd_en   = e;
        rd_addr = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({wr_ready, wr_done, rd_valid, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_status: got %b want 1000", {wr_ready, wr_done, rd_valid, busy});
        end
        n_cmp++;
        if (rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        n_cmp++;
        if ({wr_ready1, wr_done1, rd_valid1, busy1, rd_data1} !== {4'b1000, 48'h0}) begin
            n_err++;
            $display("FAIL reset_wrap_dut: got %b/%h want 1000/0", {wr_ready1, wr_done1, rd_valid1, busy1}, rd_data1);
        end
        rst = 1'b0;
    endtask

    task automatic test_overwrite();
        logic [47:0] exp [3];
        exp[0] = {16'd3, 16'd2, 16'd1};
        exp[1] = {16'd6, 16'd5, 16'd4};
        exp[2] = {16'd9, 16'd8, 16'd7};
        set_wr(1'b1, 1'b0, 3'd2, {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        step();
        set_wr(1'b0, 1'b0, 3'd0, '0);
        n_cmp++;
        if (wr_done !== 1'b1 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ow_done: got done=%b rd_valid=%b want 1/0", wr_done, rd_valid);
        end
        for (int r = 0; r < 3; r++) begin
            set_rd(1'b1, 5'(6 + r));
            step();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp[r] || wr_done !== 1'b0) begin
                n_err++;
                $display("FAIL ow_read%0d: got v=%b d=%h done=%b want 1/%h/0", 6 + r, rd_valid, rd_data, wr_done, exp[r]);
            end
        end
        set_rd(1'b0, 5'd0);
        step();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== exp[2]) begin
            n_err++;
            $display("FAIL rd_hold: got v=%b d=%h want 0/%h", rd_valid, rd_data, exp[2]);
        end
        set_rd(1'b1, 5'd25);
        step();
        set_rd(1'b0, 5'd0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL rd_out_of_range: got v=%b d=%h want 1/0", rd_valid, rd_data);
        end
    endtask

    task automatic test_accumulate();
        set_wr(1'b1, 1'b0, 3'd0, {9{16'h0005}});
        step();
        set_wr(1'b1, 1'b1, 3'd0, {9{16'hFFFE}});
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL acc_ready_T: got %b want 1", wr_ready);
        end
        step();
        set_wr(1'b0, 1'b0, 3'd0, '0);
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0 || wr_done !== 1'b0) begin
            n_err++;
            $display("FAIL acc_T1: got ready=%b done=%b want 0/0", wr_ready, wr_done);
        end
        step();
        set_rd(1'b1, 5'd0);
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1 || wr_done !== 1'b1) begin
            n_err++;
            $display("FAIL acc_T2: got ready=%b done=%b want 1/1", wr_ready, wr_done);
        end
        step();
        set_rd(1'b0, 5'd0);
        n_cmp++;
        if (rd_data !== {3{16'h0003}} || wr_done !== 1'b0) begin
            n_err++;
            $display("FAIL acc_result: got d=%h done=%b want %h/0", rd_data, wr_done, {3{16'h0003}});
        end
    endtask

    task automatic acc_and_read(input logic [2:0] blk, input logic [15:0] init, input logic [15:0] add);
        set_wr(1'b1, 1'b0, blk, {9{init}});
        step();
        set_wr(1'b1, 1'b1, blk, {9{add}});
        step();
        set_wr(1'b0, 1'b0, 3'd0, '0);
        step();
        set_rd(1'b1, 5'(int'(blk) * 3));
        step();
        set_rd(1'b0, 5'd0);
    endtask

    task automatic test_saturate();
        acc_and_read(3'd5, 16'h7FF0, 16'h0020);
        n_cmp++;
        if (rd_data !== {3{16'h7FFF}}) begin
            n_err++;
            $display("FAIL sat_pos: got %h want %h", rd_data, {3{16'h7FFF}});
        end
        n_cmp++;
        if (rd_data1 !== {3{16'h8010}}) begin
            n_err++;
            $display("FAIL wrap_pos: got %h want %h", rd_data1, {3{16'h8010}});
        end
        acc_and_read(3'd6, 16'h8010, 16'hFFC0);
        n_cmp++;
        if (rd_data !== {3{16'h8000}}) begin
            n_err++;
            $display("FAIL sat_neg: got %h want %h", rd_data, {3{16'h8000}});
        end
        n_cmp++;
        if (rd_data1 !== {3{16'h7FD0}}) begin
            n_err++;
            $display("FAIL wrap_neg: got %h want %h", rd_data1, {3{16'h7FD0}});
        end
    endtask

    task automatic test_acc_read_hazard();
        set_wr(1'b1, 1'b0, 3'd1, {9{16'h0100}});
        step();
        set_wr(1'b1, 1'b1, 3'd1, {9{16'h0011}});
        step();
        set_wr(1'b0, 1'b0, 3'd0, '0);
        set_rd(1'b1, 5'd3);
        step();
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== {3{16'h0100}} || wr_done !== 1'b1) begin
            n_err++;
            $display("FAIL hazard_pre: got v=%b d=%h done=%b want 1/%h/1", rd_valid, rd_data, wr_done, {3{16'h0100}});
        end
        step();
        set_rd(1'b0, 5'd0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== {3{16'h0111}}) begin
            n_err++;
            $display("FAIL hazard_post: got v=%b d=%h want 1/%h", rd_valid, rd_data, {3{16'h0111}});
        end
    endtask

    task automatic test_back_to_back_clear();
        for (int i = 0; i < 8; i++) begin
            set_wr(1'b1, 1'b0, 3'(i), {9{16'h1234}});
            step();
            n_cmp++;
            if (wr_done !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_done%0d: got %b want 1", i, wr_done);
            end
        end
        clear_start = 1'b1;
        set_wr(1'b1, 1'b0, 3'd0, {9{16'h5555}});
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL clr_start: got ready=%b busy=%b want 0/0", wr_ready, busy);
        end
        step();
        clear_start = 1'b0;
        set_rd(1'b1, 5'd0);
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++;
            if ({busy, wr_ready, rd_valid, wr_done} !== 4'b1000) begin
                n_err++;
                $display("FAIL clr_cycle%0d: got busy/ready/rv/done=%b want 1000", c, {busy, wr_ready, rd_valid, wr_done});
            end
            step();
        end
        set_wr(1'b0, 1'b0, 3'd0, '0);
        set_rd(1'b0, 5'd0);
        n_cmp++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_end: got busy=%b rd_valid=%b want 0/0", busy, rd_valid);
        end
        for (int r = 0; r < 24; r++) begin
            set_rd(1'b1, 5'(r));
            step();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== 48'h0) begin
                n_err++;
                $display("FAIL clr_row%0d: got v=%b d=%h want 1/0", r, rd_valid, rd_data);
            end
        end
        set_rd(1'b0, 5'd0);
    endtask

    task automatic test_reset_abort();
        logic [47:0] exp;
        for (int i = 0; i < 8; i++) begin
            set_wr(1'b1, 1'b0, 3'(i), {9{16'h1234}});
            step();
        end
        set_wr(1'b0, 1'b0, 3'd0, '0);
        set_rd(1'b1, 5'd0);
        step();
        set_rd(1'b0, 5'd0);
        set_wr(1'b1, 1'b1, 3'd4, {9{16'h0001}});
        step();
        set_wr(1'b0, 1'b0, 3'd0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({wr_ready, wr_done, rd_valid, busy} !== 4'b1000 || rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL rst_acc_outputs: got %b/%h want 1000/0", {wr_ready, wr_done, rd_valid, busy}, rd_data);
        end
        step();
        n_cmp++;
        if (wr_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_acc_no_done: got %b want 0", wr_done);
        end
        for (int r = 12; r < 15; r++) begin
            set_rd(1'b1, 5'(r));
            step();
            n_cmp++;
            if (rd_data !== {3{16'h1234}}) begin
                n_err++;
                $display("FAIL rst_acc_row%0d: got %h want %h", r, rd_data, {3{16'h1234}});
            end
        end
        set_rd(1'b0, 5'd0);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_clr_busy: got %b want 0", busy);
        end
        for (int r = 0; r < 24; r++) begin
            exp = (r < 9) ? 48'h0 : {3{16'h1234}};
            set_rd(1'b1, 5'(r));
            step();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                n_err++;
                $display("FAIL rst_clr_row%0d: got v=%b d=%h want 1/%h", r, rd_valid, rd_data, exp);
            end
        end
        set_rd(1'b0, 5'd0);
    endtask

    initial begin
        test_reset();
        test_overwrite();
        test_accumulate();
        test_saturate();
        test_acc_read_hazard();
        test_back_to_back_clear();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
